// File: rtl/seq_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_core_if
// Brief    : Operand/handshake/result bundle for the sequential ALU core.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_core_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [3:0]           opcode;
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;
    logic                 done;
    logic                 divByZero;

    modport master (
        output start, opcode, opA, opB,
        input  result, busy, done, divByZero
    );

    modport slave (
        input  start, opcode, opA, opB,
        output result, busy, done, divByZero
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_core
// Brief    : Registered ALU: twelve single-cycle ops plus iterative
//            unsigned/signed multiply and restoring unsigned divide.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(2*WIDTH)
) (
    input  wire logic     pulse,
    input  wire logic     reset,
    seq_alu_core_if.slave bus
);
    localparam int RW = 2*WIDTH;
    localparam int CW = $clog2(WIDTH+1);

    localparam logic [3:0]   c_op_umul = 4'd12;
    localparam logic [3:0]   c_op_smul = 4'd13;
    localparam logic [3:0]   c_op_udiv = 4'd14;
    localparam logic [SHW:0] c_rw      = (SHW+1)'(RW);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [RW-1:0]    r_result;
    logic             r_done;
    logic             r_dbz;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_acc;
    logic [WIDTH-1:0] r_opnd;
    logic             r_neg;
    logic             r_isdiv;

    logic             w_go_single;
    logic             w_go_iter;
    logic             w_finish;
    logic             w_bz;
    logic             w_iter_op;

    logic [RW-1:0]    w_sea;
    logic [RW-1:0]    w_seb;
    logic [RW-1:0]    w_zea;
    logic [SHW-1:0]   w_shamt;
    logic [SHW:0]     w_shinv;
    logic [RW-1:0]    w_alu;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_is_smul;
    logic [WIDTH:0]   w_sum;
    logic [RW-1:0]    w_mul_nxt;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic [RW-1:0]    w_div_nxt;
    logic [RW-1:0]    w_acc_nxt;
    logic [RW-1:0]    w_final;

    assign bus.result    = r_result;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = r_done;
    assign bus.divByZero = r_dbz;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    assign w_sea   = {{WIDTH{bus.opA[WIDTH-1]}}, bus.opA};
    assign w_seb   = {{WIDTH{bus.opB[WIDTH-1]}}, bus.opB};
    assign w_zea   = {{WIDTH{1'b0}}, bus.opA};
    assign w_shamt = bus.opB[SHW-1:0];
    // A complementary shift of RW (amount 0) yields zero, so rotate-by-0 is A.
    assign w_shinv = c_rw - {1'b0, w_shamt};
    assign w_bz    = (bus.opB == '0);

    always_comb begin
        w_alu = '0;
        case (bus.opcode)
            4'd0:  w_alu = w_sea + w_seb;
            4'd1:  w_alu = w_sea - w_seb;
            4'd2:  w_alu = w_seb - w_sea;
            4'd3:  w_alu = '0 - w_sea;
            4'd4:  w_alu = {{WIDTH{1'b0}}, bus.opA & bus.opB};
            4'd5:  w_alu = {{WIDTH{1'b0}}, bus.opA | bus.opB};
            4'd6:  w_alu = {{WIDTH{1'b0}}, bus.opA ^ bus.opB};
            4'd7:  w_alu = {{WIDTH{1'b0}}, ~bus.opA};
            4'd8:  w_alu = (w_zea >> w_shamt) | (w_zea << w_shinv);
            4'd9:  w_alu = (w_zea << w_shamt) | (w_zea >> w_shinv);
            4'd10: w_alu = $signed(w_sea) >>> w_shamt;
            4'd11: w_alu = w_sea << w_shamt;
            4'd14: w_alu = {bus.opA, {WIDTH{1'b1}}};
            default: w_alu = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative datapath: r_acc holds {partial, multiplier} for multiply
    // and {remainder, dividend/quotient} for divide.
    // ------------------------------------------------------------------
    assign w_is_smul = (bus.opcode == c_op_smul);
    assign w_mag_a   = (w_is_smul && bus.opA[WIDTH-1]) ? (~bus.opA + 1'b1) : bus.opA;
    assign w_mag_b   = (w_is_smul && bus.opB[WIDTH-1]) ? (~bus.opB + 1'b1) : bus.opB;

    assign w_sum     = {1'b0, r_acc[RW-1:WIDTH]} + {1'b0, {WIDTH{r_acc[0]}} & r_opnd};
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

    assign w_trial   = r_acc[RW-1:WIDTH-1];
    assign w_diff    = w_trial - {1'b0, r_opnd};
    assign w_div_nxt = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_acc_nxt = r_isdiv ? w_div_nxt : w_mul_nxt;
    assign w_final   = r_neg ? ('0 - w_acc_nxt) : w_acc_nxt;

    assign w_iter_op = (bus.opcode == c_op_umul) || (bus.opcode == c_op_smul) ||
                       ((bus.opcode == c_op_udiv) && !w_bz);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pulse or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go_single = 1'b0;
        w_go_iter   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_iter_op) begin
                        w_go_iter   = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_go_single = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge pulse or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_isdiv  <= 1'b0;
        end else begin
            r_done <= w_go_single | w_finish;
            if (w_go_single) begin
                r_result <= w_alu;
                r_dbz    <= (bus.opcode == c_op_udiv) && w_bz;
            end
            if (w_go_iter) begin
                r_cnt   <= CW'(WIDTH);
                r_isdiv <= (bus.opcode == c_op_udiv);
                r_neg   <= w_is_smul && (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
                if (bus.opcode == c_op_udiv) begin
                    r_opnd <= bus.opB;
                    r_acc  <= {{WIDTH{1'b0}}, bus.opA};
                end else begin
                    r_opnd <= w_mag_a;
                    r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                end
            end
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
                r_acc <= w_acc_nxt;
            end
            if (w_finish) begin
                r_result <= w_final;
                r_dbz    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_core
// Brief    : Directed vector bench for seq_alu_core at WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_core;
    localparam int W = 8;

    logic pulse = 1'b0;
    logic reset = 1'b0;

    seq_alu_core_if #(.WIDTH(W)) bus ();

    seq_alu_core #(.WIDTH(W)) dut (
        .pulse (pulse),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pulse = ~pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          disturb;
        logic [15:0] exp_res;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge pulse);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op and watches a fixed window; lat is the observation index
    // of the first done (0 = visible right after the accepting edge).
    task automatic do_op(input vec_t v, output logic [15:0] res, output logic dbz,
                         output int lat, output int nbusy, output int ndone, output bit both);
        bus.opcode = v.op;
        bus.opA    = v.a;
        bus.opB    = v.b;
        bus.start  = 1'b1;
        step();
        bus.start = 1'b0;
        res = 'x; dbz = 1'bx; lat = -1; nbusy = 0; ndone = 0; both = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (i > 0) step();
            if (v.disturb && i == 3) begin
                bus.opA = 8'h12; bus.opB = 8'h34; bus.opcode = 4'd0; bus.start = 1'b1;
            end
            if (v.disturb && i == 4) bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) both = 1'b1;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = i; res = bus.result; dbz = bus.divByZero;
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] res;
        logic        dbz;
        int          lat, nbusy, ndone, first, second;
        bit          both;
        logic [15:0] r1, r2;

        bus.start = 1'b0; bus.opcode = 4'd0; bus.opA = 8'h00; bus.opB = 8'h00;
        #1 reset = 1'b1;
        #1;
        chk("reset_result", 32'(bus.result), 32'h0);
        chk("reset_busy",   32'(bus.busy),   32'h0);
        chk("reset_done",   32'(bus.done),   32'h0);
        chk("reset_dbz",    32'(bus.divByZero), 32'h0);
        step();
        reset = 1'b0;
        step();

        vecs.push_back(vec_t'{4'd0,  8'h80, 8'hFF, 1'b0, 16'hFF7F, 1'b0, 0});
        vecs.push_back(vec_t'{4'd10, 8'h90, 8'h03, 1'b0, 16'hFFF2, 1'b0, 0});
        vecs.push_back(vec_t'{4'd9,  8'h81, 8'h09, 1'b0, 16'h0201, 1'b0, 0});
        vecs.push_back(vec_t'{4'd7,  8'h0F, 8'h00, 1'b0, 16'h00F0, 1'b0, 0});
        vecs.push_back(vec_t'{4'd1,  8'h05, 8'h03, 1'b0, 16'h0002, 1'b0, 0});
        vecs.push_back(vec_t'{4'd2,  8'h05, 8'h03, 1'b0, 16'hFFFE, 1'b0, 0});
        vecs.push_back(vec_t'{4'd3,  8'h01, 8'h00, 1'b0, 16'hFFFF, 1'b0, 0});
        vecs.push_back(vec_t'{4'd5,  8'hF0, 8'h0F, 1'b0, 16'h00FF, 1'b0, 0});
        vecs.push_back(vec_t'{4'd6,  8'hFF, 8'h0F, 1'b0, 16'h00F0, 1'b0, 0});
        vecs.push_back(vec_t'{4'd8,  8'h01, 8'h01, 1'b0, 16'h8000, 1'b0, 0});
        vecs.push_back(vec_t'{4'd11, 8'h81, 8'h04, 1'b0, 16'hF810, 1'b0, 0});
        vecs.push_back(vec_t'{4'd15, 8'hAA, 8'h55, 1'b0, 16'h0000, 1'b0, 0});
        vecs.push_back(vec_t'{4'd12, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, W});
        vecs.push_back(vec_t'{4'd12, 8'hFF, 8'hFF, 1'b1, 16'hFE01, 1'b0, W});
        vecs.push_back(vec_t'{4'd13, 8'hFD, 8'h05, 1'b0, 16'hFFF1, 1'b0, W});
        vecs.push_back(vec_t'{4'd13, 8'h80, 8'h80, 1'b0, 16'h4000, 1'b0, W});
        vecs.push_back(vec_t'{4'd13, 8'h80, 8'h7F, 1'b0, 16'hC080, 1'b0, W});
        vecs.push_back(vec_t'{4'd14, 8'd100, 8'd7, 1'b0, 16'h020E, 1'b0, W});
        vecs.push_back(vec_t'{4'd14, 8'h64, 8'h00, 1'b0, 16'h64FF, 1'b1, 0});
        vecs.push_back(vec_t'{4'd0,  8'h01, 8'h01, 1'b0, 16'h0002, 1'b0, 0});
        vecs.push_back(vec_t'{4'd14, 8'hFF, 8'h10, 1'b0, 16'h0F0F, 1'b0, W});

        foreach (vecs[k]) begin
            do_op(vecs[k], res, dbz, lat, nbusy, ndone, both);
            chk($sformatf("vec%0d_result", k), 32'(res), 32'(vecs[k].exp_res));
            chk($sformatf("vec%0d_dbz", k), 32'(dbz), 32'(vecs[k].exp_dbz));
            chk($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].exp_lat));
            chk($sformatf("vec%0d_done_count", k), 32'(ndone), 32'd1);
            chk($sformatf("vec%0d_busy_cycles", k), 32'(nbusy), 32'(vecs[k].exp_lat));
            chk($sformatf("vec%0d_done_busy_overlap", k), 32'(both), 32'd0);
            chk($sformatf("vec%0d_result_hold", k), 32'(bus.result), 32'(vecs[k].exp_res));
        end

        // Asynchronous reset asserted between edges clears outputs at once.
        @(posedge pulse);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_result", 32'(bus.result), 32'h0);
        chk("async_reset_busy",   32'(bus.busy),   32'h0);
        chk("async_reset_dbz",    32'(bus.divByZero), 32'h0);
        step();
        reset = 1'b0;
        step();

        // Reset during a multiply aborts it without a done pulse.
        bus.opcode = 4'd12; bus.opA = 8'hFF; bus.opB = 8'hFF; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("midrun_busy_before_reset", 32'(bus.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("midrun_reset_busy",   32'(bus.busy),   32'h0);
        chk("midrun_reset_result", 32'(bus.result), 32'h0);
        step();
        reset = 1'b0;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < W + 4; i++) begin
            step();
            if (bus.done) ndone++;
            if (bus.busy) nbusy++;
        end
        chk("midrun_no_done", 32'(ndone), 32'h0);
        chk("midrun_no_busy", 32'(nbusy), 32'h0);

        // start held high: multiply, then an AND accepted on the first idle edge.
        bus.opcode = 4'd12; bus.opA = 8'd3; bus.opB = 8'd4; bus.start = 1'b1;
        step();
        chk("b2b_busy_after_start", 32'(bus.busy), 32'h1);
        bus.opcode = 4'd4; bus.opA = 8'hF0; bus.opB = 8'h3C;
        first = -1; second = -1; r1 = '0; r2 = '0;
        for (int idx = 1; idx <= W + 1; idx++) begin
            step();
            if (bus.done) begin
                if (first < 0) begin
                    first = idx; r1 = bus.result;
                end else if (second < 0) begin
                    second = idx; r2 = bus.result;
                end
            end
        end
        bus.start = 1'b0;
        chk("b2b_mul_done_index", 32'(first), 32'(W));
        chk("b2b_mul_result",     32'(r1),    32'h000C);
        chk("b2b_and_done_index", 32'(second), 32'(W + 1));
        chk("b2b_and_result",     32'(r2),    32'h0030);
        step();
        step();
        chk("b2b_final_idle", 32'(bus.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
